instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential encoder that packs symbolic instructions (mnemonic plus register and immediate fields) into the core's 9-bit instruction words and writes them to instruction memory at consecutive addresses. It is the producing end of the instruction format that the core's decoder consumes. It loads programs into instruction RAM for emulation runs, and it stops after emitting HALT.

## Interface
- DEPTH, 256: instruction memory words; ADDR_W = $clog2(DEPTH)
- clk  input  1  clock
- reset  input  1  reset; asynchronous, active-high
- start  input  1  pulse: clear address/flags, enter RUN
- in_valid  input  1  instruction fields valid
- in_ready  output  1  encoder accepts fields this cycle
- mnem  input  4  0 AND, 1 SLT, 2 OR, 3 JR, 4 LW, 5 SW, 6 ADD, 7 ADDI, 8 TR1, 9 TR2, 15 HALT; others illegal
- ra, rb, rc  input  4 each  register operands
- imm  input  2  ADDI immediate
- imem_we  output  1  write strobe
- imem_addr  output  ADDR_W  write address
- imem_wdata  output  9  encoded word
- done  output  1  HALT written
- err  output  1  sticky error
- err_code  output  2  00 none, 01 illegal mnemonic, 10 operand range, 11 memory full
- err_addr  output  ADDR_W  address of first error
- count  output  ADDR_W+1  words written

## Operation
- FSM: IDLE -> (start) RUN -> (HALT accepted) DONE, or (non-HALT write at DEPTH-1) FULL. start from any state -> RUN.
- in_ready = (state == RUN). Accept = in_valid & in_ready.
- Encoding, with {opcode[8:6], field[5:0]}:
  - AND/SLT/OR/JR: {000, ra[1:0], (rb-4)[1:0], sub}, where sub is 00/01/10/11. ra 0-3, rb 4-7.
  - LW: {001, ra[1:0], (rb-4)[1:0], 00}. ra is the destination 0-3; rb is the address register 4-7.
  - SW: {001, ra[1:0], (rb-4)[1:0], 01}. ra is the address register 0-3; rb is the data register 4-7.
  - ADD: {010, ra[1:0], (rb-4)[1:0], (rc-8)[1:0]}. ra 0-3, rb 4-7, rc 8-11.
  - ADDI: {011, ra[1:0], (rc-8)[1:0], imm}. ra 0-3, rc 8-11.
  - TR1: {100, ra[2:0], (rb-4)[2:0]}. ra is the destination 0-7; rb is the source 4-11.
  - TR2: {101, ra[2:0], (rb-4)[2:0]}. ra is the source 0-7; rb is the destination 4-11.
  - HALT: 9'b111_000000.
- Illegal mnemonic:
  - Consumes the handshake, writes nothing, and does not advance the address.
  - If err is 0, sets err = 1, err_code = 01, err_addr = current address. Later errors are not recorded.
- Address:
  - Increments on every issued write.
  - Never wraps. A non-HALT write to DEPTH-1 enters FULL and sets err_code 11 if no error is recorded yet; err_addr = DEPTH-1.
  - HALT written at DEPTH-1 enters DONE with no error.
- DONE/FULL: in_ready = 0; all input is ignored until start.

## Timing
- Reset values:
  - state IDLE.
  - in_ready, imem_we, done, err all 0.
  - err_code 00; imem_addr, err_addr, imem_wdata, count all 0.
- Latency: fields accepted at edge N. imem_we, imem_addr and imem_wdata are registered and valid during cycle N+1. count updates at edge N+1.
- Throughput: one word per cycle with in_valid held high.
- HALT accepted at edge N: in_ready = 0 from cycle N+1. The HALT write occurs in N+1. done = 1 from N+1 until start/reset.
- FULL: in_ready = 0 from the cycle after the final accept. err is visible in the same cycle as the final write.
- start takes priority over accept in the same cycle:
  - A pending write stage is cancelled (no imem_we next cycle).
  - Address, count, done and err are cleared at that edge.
- Reset asserted mid-run: all outputs return to reset values immediately. No write strobe is emitted after the reset edge.

## Configuration
- ENCODER_RANGE_CHECK_EN defined:
  - Any operand outside its listed range is handled as for an illegal mnemonic, with err_code 10: no write, no advance.
  - ra, rb and rc are checked only where the mnemonic uses them.
- Undefined:
  - No range check. Fields are truncated after subtraction as written in the encoding list; for example, ADD with rb = 9 encodes (9-4)[1:0] = 01.
  - err_code 10 never occurs.

## Test plan
- Reset, start, then ADD ra=1 rb=6 rc=11: imem_wdata = 9'b010_01_10_11 at addr 0, imem_we for exactly one cycle, count = 1.
- Back-to-back stream AND(0,4), SLT(3,7), ADDI(2,9,imm=3), TR2(5,11), HALT:
  - Expected words 000_00_00_00, 000_11_11_01, 011_10_01_11, 101_101_111, 111_000000 at addrs 0-4.
  - done rises with the HALT write; in_ready is low afterwards.
- mnem = 12 between two valid words:
  - Words land at consecutive addresses 0 and 1.
  - err = 1, err_code 01, err_addr = 1.
- With ENCODER_RANGE_CHECK_EN, ADD rb = 2:
  - No write; err_code 10.
  - Without the macro, the word written is 010_xx_10_xx.
- DEPTH = 4, five non-HALT words:
  - Four writes occur, then FULL with err_code 11, err_addr = 3, in_ready = 0.
  - A subsequent start resumes at addr 0.
- Reset asserted in the cycle after an accept: no imem_we is observed and all outputs read zero.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic instructions into 9-bit words and writes them to consecutive imem addresses.
// Optional build macro ENCODER_RANGE_CHECK_EN rejects out-of-range register operands with err_code 10.
module instr_encoder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        mnem,
    input  logic [3:0]        ra,
    input  logic [3:0]        rb,
    input  logic [3:0]        rc,
    input  logic [1:0]        imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [8:0]        imem_wdata,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ADDR_W:0]   count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE, FULL} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    state_t state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [2:0] rb4;
    logic [1:0] rc8;
    logic [8:0] word;
    logic legal, in_range, is_halt, accept, wr, at_last;

    assign rb4     = 3'(rb - 4'd4);
    assign rc8     = 2'(rc - 4'd8);
    assign accept  = in_valid & in_ready;
    assign wr      = accept & legal & in_range;
    assign is_halt = mnem == 4'd15;
    assign at_last = addr == LAST;

    // Field packing per mnemonic; undefined mnemonics clear legal
    always_comb begin
        legal = 1'b1;
        word  = 9'd0;
        case (mnem)
            4'd0, 4'd1, 4'd2, 4'd3: word = {3'b000, ra[1:0], rb4[1:0], mnem[1:0]};
            4'd4, 4'd5:             word = {3'b001, ra[1:0], rb4[1:0], 1'b0, mnem[0]};
            4'd6:                   word = {3'b010, ra[1:0], rb4[1:0], rc8};
            4'd7:                   word = {3'b011, ra[1:0], rc8, imm};
            4'd8, 4'd9:             word = {2'b10, mnem[0], ra[2:0], rb4};
            4'd15:                  word = 9'b111_000000;
            default:                legal = 1'b0;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    // Operand ranges, checked only for the fields each mnemonic consumes
    always_comb begin
        in_range = 1'b1;
        case (mnem)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: in_range = ra[3:2] == 2'b00 && rb[3:2] == 2'b01;
            4'd6:       in_range = ra[3:2] == 2'b00 && rb[3:2] == 2'b01 && rc[3:2] == 2'b10;
            4'd7:       in_range = ra[3:2] == 2'b00 && rc[3:2] == 2'b10;
            4'd8, 4'd9: in_range = !ra[3] && rb >= 4'd4 && rb <= 4'd11;
            default:    in_range = 1'b1;
        endcase
    end
`else
    logic unused_ra_msb;
    assign unused_ra_msb = ra[3];
    assign in_range = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    // start restarts from anywhere; a write ends the run on HALT or on the last word
    always_comb begin
        state_n = state;
        if (start) state_n = RUN;
        else if (wr && is_halt) state_n = DONE;
        else if (wr && at_last) state_n = FULL;
    end

    // Fields are only taken while running
    always_comb in_ready = state == RUN;

    // Registered write stage, address/count tracking and sticky first-error capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 9'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            err_addr   <= '0;
            count      <= '0;
        end else if (start) begin
            addr       <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 9'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
            err_addr   <= '0;
            count      <= '0;
        end else begin
            count   <= count + (ADDR_W+1)'(imem_we);
            imem_we <= wr;
            if (wr) begin
                imem_addr  <= addr;
                imem_wdata <= word;
                if (!at_last) addr <= addr + ADDR_W'(1);
            end
            if (wr && is_halt) done <= 1'b1;
            if (wr && !is_halt && at_last && !err) begin
                err      <= 1'b1;
                err_code <= 2'b11;
                err_addr <= LAST;
            end
            if (accept && !wr && !err) begin
                err      <= 1'b1;
                err_code <= legal ? 2'b10 : 2'b01;
                err_addr <= addr;
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed stimulus with a write scoreboard for a full-size and a 4-word encoder.
module tb_instr_encoder;
    typedef struct packed {
        logic [7:0] a;
        logic [8:0] d;
    } exp_t;

    logic clk, reset;
    logic start0, start1, v0, v1;
    logic [3:0] mnem, ra, rb, rc;
    logic [1:0] imm;
    logic rdy0, we0, done0, err0;
    logic [7:0] addr0, eaddr0;
    logic [8:0] wd0, cnt0;
    logic [1:0] ec0;
    logic rdy1, we1, done1, err1;
    logic [1:0] addr1, eaddr1, ec1;
    logic [8:0] wd1;
    logic [2:0] cnt1;
    exp_t q0[$], q1[$];
    logic [7:0] wa0, wa1;
    int n_cmp = 0;
    int n_fail = 0;

    instr_encoder dut (
        .clk(clk), .reset(reset), .start(start0), .in_valid(v0), .in_ready(rdy0),
        .mnem(mnem), .ra(ra), .rb(rb), .rc(rc), .imm(imm),
        .imem_we(we0), .imem_addr(addr0), .imem_wdata(wd0), .done(done0),
        .err(err0), .err_code(ec0), .err_addr(eaddr0), .count(cnt0)
    );

    instr_encoder #(.DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start1), .in_valid(v1), .in_ready(rdy1),
        .mnem(mnem), .ra(ra), .rb(rb), .rc(rc), .imm(imm),
        .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1), .done(done1),
        .err(err1), .err_code(ec1), .err_addr(eaddr1), .count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic settle(input int n);
        idle();
        repeat (n) tick();
    endtask

    task automatic do_start(input int sel);
        idle();
        if (sel == 0) begin start0 = 1'b1; wa0 = 8'd0; end
        else begin start1 = 1'b1; wa1 = 8'd0; end
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic send(input int sel, input logic [3:0] m, a, b, c, input logic [1:0] i,
                        input bit push, input logic [8:0] w);
        mnem = m; ra = a; rb = b; rc = c; imm = i;
        if (sel == 0) v0 = 1'b1;
        else v1 = 1'b1;
        if (push && sel == 0) begin q0.push_back({wa0, w}); wa0++; end
        if (push && sel != 0) begin q1.push_back({wa1, w}); wa1++; end
        tick();
    endtask

    // Scoreboard for the full-size encoder
    always @(negedge clk) begin
        exp_t e;
        if (we0) begin
            if (q0.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL wr0_unexpected: got write addr %0d data %b, expected no write", addr0, wd0);
            end else begin
                e = q0.pop_front();
                check("wr0_addr", 32'(addr0), 32'(e.a));
                check("wr0_data", 32'(wd0), 32'(e.d));
            end
        end
    end

    // Scoreboard for the 4-word encoder
    always @(negedge clk) begin
        exp_t e;
        if (we1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL wr1_unexpected: got write addr %0d data %b, expected no write", addr1, wd1);
            end else begin
                e = q1.pop_front();
                check("wr1_addr", 32'(addr1), 32'(e.a));
                check("wr1_data", 32'(wd1), 32'(e.d));
            end
        end
    end

    initial begin
        logic [1:0] kk;
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; v0 = 1'b0; v1 = 1'b0;
        mnem = 4'd0; ra = 4'd0; rb = 4'd0; rc = 4'd0; imm = 2'd0; wa0 = 8'd0; wa1 = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(rdy0), 0);
        check("rst_we", 32'(we0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_err", 32'(err0), 0);
        check("rst_code", 32'(ec0), 0);
        check("rst_addr", 32'(addr0), 0);
        check("rst_eaddr", 32'(eaddr0), 0);
        check("rst_wdata", 32'(wd0), 0);
        check("rst_count", 32'(cnt0), 0);
        reset = 1'b0;
        tick();

        do_start(0);
        check("ready_after_start", 32'(rdy0), 1);
        send(0, 4'd6, 4'd1, 4'd6, 4'd11, 2'd0, 1, 9'b010_01_10_11);
        settle(2);
        check("add_count", 32'(cnt0), 1);
        check("add_err", 32'(err0), 0);

        do_start(0);
        send(0, 4'd0, 4'd0, 4'd4, 4'd0, 2'd0, 1, 9'b000_00_00_00);
        send(0, 4'd1, 4'd3, 4'd7, 4'd0, 2'd0, 1, 9'b000_11_11_01);
        send(0, 4'd7, 4'd2, 4'd0, 4'd9, 2'd3, 1, 9'b011_10_01_11);
        send(0, 4'd9, 4'd5, 4'd11, 4'd0, 2'd0, 1, 9'b101_101_111);
        send(0, 4'd15, 4'd0, 4'd0, 4'd0, 2'd0, 1, 9'b111_000000);
        check("halt_done", 32'(done0), 1);
        check("halt_ready", 32'(rdy0), 0);
        send(0, 4'd6, 4'd1, 4'd6, 4'd11, 2'd0, 0, 9'd0);
        settle(2);
        check("stream_count", 32'(cnt0), 5);
        check("stream_done_held", 32'(done0), 1);

        do_start(0);
        check("start_clears_done", 32'(done0), 0);
        send(0, 4'd6, 4'd1, 4'd6, 4'd11, 2'd0, 1, 9'b010_01_10_11);
        send(0, 4'd12, 4'd0, 4'd0, 4'd0, 2'd0, 0, 9'd0);
        send(0, 4'd8, 4'd7, 4'd4, 4'd0, 2'd0, 1, 9'b100_111_000);
        settle(1);
        check("illegal_err", 32'(err0), 1);
        check("illegal_code", 32'(ec0), 1);
        check("illegal_eaddr", 32'(eaddr0), 1);
        send(0, 4'd13, 4'd0, 4'd0, 4'd0, 2'd0, 0, 9'd0);
        settle(2);
        check("first_err_kept", 32'(eaddr0), 1);
        check("illegal_count", 32'(cnt0), 2);

        do_start(0);
        check("start_clears_err", 32'(err0), 0);
        send(0, 4'd6, 4'd1, 4'd2, 4'd8, 2'd0, 1, 9'b010_01_10_00);
        settle(2);
        check("norange_err", 32'(err0), 0);
        check("norange_count", 32'(cnt0), 1);

        mnem = 4'd6; ra = 4'd1; rb = 4'd6; rc = 4'd11; v0 = 1'b1; start0 = 1'b1; wa0 = 8'd0;
        tick();
        start0 = 1'b0;
        check("start_cancel_we", 32'(we0), 0);
        settle(2);
        check("start_cancel_count", 32'(cnt0), 0);
        check("start_cancel_ready", 32'(rdy0), 1);

        do_start(1);
        check("small_ready", 32'(rdy1), 1);
        for (int k = 0; k < 4; k++) begin
            kk = 2'(k);
            send(1, 4'd6, 4'(k), 4'(k + 4), 4'(k + 8), 2'd0, 1, {3'b010, kk, kk, kk});
        end
        check("full_err", 32'(err1), 1);
        check("full_code", 32'(ec1), 3);
        check("full_eaddr", 32'(eaddr1), 3);
        check("full_ready", 32'(rdy1), 0);
        send(1, 4'd6, 4'd0, 4'd4, 4'd8, 2'd0, 0, 9'd0);
        settle(2);
        check("full_count", 32'(cnt1), 4);
        check("full_done", 32'(done1), 0);
        do_start(1);
        check("resume_err", 32'(err1), 0);
        check("resume_ready", 32'(rdy1), 1);
        send(1, 4'd0, 4'd0, 4'd4, 4'd0, 2'd0, 1, 9'b000_00_00_00);
        settle(2);
        check("resume_count", 32'(cnt1), 1);

        do_start(0);
        send(0, 4'd6, 4'd0, 4'd4, 4'd8, 2'd0, 0, 9'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_we", 32'(we0), 0);
        check("mid_rst_ready", 32'(rdy0), 0);
        check("mid_rst_addr", 32'(addr0), 0);
        check("mid_rst_wdata", 32'(wd0), 0);
        check("mid_rst_done", 32'(done0), 0);
        check("mid_rst_err", 32'({err0, ec0, eaddr0}), 0);
        check("mid_rst_count", 32'(cnt0), 0);
        @(negedge clk);
        check("mid_rst_we_held", 32'(we0), 0);
        reset = 1'b0;
        tick();
        check("q0_drained", 32'(q0.size()), 0);
        check("q1_drained", 32'(q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
